seg7_scan: RTL and testbench
============================

Name: seg7_scan

Overview:
- Multiplexed 8-digit seven-segment display driver, directly downstream of the stopwatch/clock counters.
- Consumes the 32-bit packed nibble word those blocks produce, e.g. {hr_10,hr_1,4'hB,min_10,min_1,4'hB,sec_10,sec_1}. Nibble 0xB is the separator.
- Scans one digit at a time, decodes each nibble to segments, and drives the board's active-low anodes, segments and decimal point.
- Adds anti-ghost blanking, frame-coherent input snapshot and per-digit blink.

Parameters:
- DIV, 12500: clocks per digit slot (100 MHz gives 8 kHz digit rate, 1 kHz frame). Must be >= 2.
- BLANK_CYC, 250: clocks at the start of each slot with all anodes off. Must be < DIV.
- BLINK_FRAMES, 250: frames per blink half-period (2 Hz blink at defaults). Must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- value  in  32  packed display word; digit d = value[4d+3:4d], digit 0 is rightmost
- dp_mask  in  8  1 = light decimal point on digit d
- blink_mask  in  8  1 = digit d blinks
- an  out  8  anode enables, active-low, one-hot-low when active
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse at start of each frame

Behaviour:
- State:
  - cnt: 0..DIV-1, slot counter.
  - idx: 0..7, digit index.
  - fcnt: 0..BLINK_FRAMES-1, frame counter.
  - bph: blink phase.
  - snap: snapshot of value, dp_mask and blink_mask.
- Reset (synchronous, dominant over all other events):
  - cnt=0, idx=0, fcnt=0, bph=0, snap=0.
  - Outputs: an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
  - Reset asserted mid-scan: outputs return to these values on the next edge; scanning restarts at digit 0.
- Counting:
  - cnt increments every clock. At DIV-1 it wraps to 0 and idx increments, 7 wraps to 0.
  - On the idx 7->0 wrap, fcnt increments. At BLINK_FRAMES-1, fcnt wraps to 0 and bph toggles.
- Snapshot: snap loads value, dp_mask and blink_mask on every cycle with cnt==0 and idx==0, including the first cycle after reset. The display never tears mid-frame. Input changes become visible only from the next frame.
- Outputs are registered from current state, giving one cycle of latency.
  - cnt < BLANK_CYC: an=FF, seg=7F, dp=1.
  - Otherwise: an = ~(1<<idx), seg = decode(snap nibble idx), dp = ~snap_dp[idx].
  - Blink: if snap_blink[idx] and bph==1, then seg=7F and dp=1 for that digit. The anode still scans.
- frame_tick is registered high for exactly one cycle, one clock after the snapshot cycle (cnt==0, idx==0). It is high on the first edge after reset release.
- Timing after reset release (edge 1 = first edge): an[0] first goes low on edge BLANK_CYC+1. Each digit is active DIV-BLANK_CYC cycles; a frame is 8*DIV cycles.
- Decode (active-low), 0-9: 40,79,24,30,19,12,02,78,00,10.
- Decode, A-F: A=08 ('A'), B=3F (dash, separator), C=46, D=21 ('d'), E=06, F=7F (blank).
- All values 16 codes are defined; no X on any output.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS=8, NIB_SEP=4'hB, NIB_BLANK=4'hF.
  - SEG_OFF=7'h7F, AN_OFF=8'hFF.
  - The 16-entry segment constant table.
- One combinational sub-module seg7_decode (nibble in, seg out), reusable by other display blocks. Counters, snapshot and output registers stay in seg7_scan.

Test Plan:
All scenarios use DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
1. Reset release, value=32'h19B49B54 -> an=FF/seg=7F during reset; edge 3 gives an=FE, seg=19; slot 1 seg=12; slot 2 seg=3F; slot 7 seg=79.
2. Free-run 2 frames -> an sequence FE,FD,FB,F7,EF,DF,BF,7F, each low 6 cycles with FF for 2 cycles between; frame_tick period exactly 64 cycles.
3. Change value to 32'h00000000 while digit 3 active -> digits 3-7 keep old values; all digits show 40 only after next frame_tick.
4. value sweeps nibbles 0..F on digit 0 per frame -> seg matches the decode table for all 16 codes; dp_mask=8'h01 -> dp=0 only while an=FE.
5. blink_mask=8'h03 -> digits 0,1 show seg=7F/dp=1 for frames 2-3, visible frames 0-1 and 4-5; other digits never blanked.
6. Reset asserted while an=DF -> next edge an=FF, seg=7F, dp=1; after release the scan restarts at an=FE on edge 3.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks: digit count,
// special nibble codes, inactive output levels and the segment table.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [3:0] NIB_SEP   = 4'hB;
    localparam logic [3:0] NIB_BLANK = 4'hF;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry 15 leftmost, entry 0 rightmost.
    // 0xB renders as a dash (separator) and 0xF is fully blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h7F, 7'h06, 7'h21, 7'h46, 7'h3F, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment decoder. Every one of the 16 codes
// has a defined pattern, so the output can never go unknown.
module seg7_decode (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    // Table lookup of the segment pattern for the incoming nibble.
    always_comb begin
        seg = SEG_TABLE[nib];
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 8-digit seven-segment scanner. Steps through the digits one
// slot at a time, blanks all anodes at the start of every slot to stop
// ghosting, latches the display word once per frame so a frame never
// tears, and can blink individual digits at a slow frame-derived rate.
module seg7_scan #(
    parameter int DIV          = 12500,
    parameter int BLANK_CYC    = 250,
    parameter int BLINK_FRAMES = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);
    import seg7_pkg::*;

    localparam int CW = $clog2(DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);
    localparam logic [CW-1:0] BLANK_LIM  = CW'(BLANK_CYC);
    localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FCNT_ONE   = FW'(32'd1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0] IDX_ONE    = IW'(32'd1);

    // Scan state
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          bph_q, bph_d;

    // Per-frame snapshot of the inputs
    logic [31:0]   snap_val_q, snap_val_d;
    logic [7:0]    snap_dp_q, snap_dp_d;
    logic [7:0]    snap_blink_q, snap_blink_d;

    // Output registers
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          ft_q, ft_d;

    // Combinational helpers
    logic          frame_start_s;
    logic          slot_end_s;
    logic          frame_end_s;
    logic          blank_s;
    logic          blink_off_s;
    logic [3:0]    nib_s;
    logic [6:0]    dec_seg_s;

    assign frame_start_s = (cnt_q == '0) && (idx_q == '0);
    assign slot_end_s    = (cnt_q == CNT_LAST);
    assign frame_end_s   = slot_end_s && (idx_q == IDX_LAST);
    assign blank_s       = (cnt_q < BLANK_LIM);
    assign blink_off_s   = snap_blink_q[idx_q] & bph_q;
    assign nib_s         = snap_val_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .nib (nib_s),
        .seg (dec_seg_s)
    );

    // Next-state for slot counter, digit index, frame counter and blink phase.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        fcnt_d = fcnt_q;
        bph_d  = bph_q;
        if (slot_end_s) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
            if (frame_end_s) begin
                if (fcnt_q == FCNT_LAST) begin
                    fcnt_d = '0;
                    bph_d  = ~bph_q;
                end else begin
                    fcnt_d = fcnt_q + FCNT_ONE;
                end
            end else begin
                fcnt_d = fcnt_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Latch the display inputs once per frame, on the first cycle of digit 0.
    always_comb begin
        snap_val_d   = snap_val_q;
        snap_dp_d    = snap_dp_q;
        snap_blink_d = snap_blink_q;
        if (frame_start_s) begin
            snap_val_d   = value;
            snap_dp_d    = dp_mask;
            snap_blink_d = blink_mask;
        end else begin
            snap_val_d   = snap_val_q;
            snap_dp_d    = snap_dp_q;
            snap_blink_d = snap_blink_q;
        end
    end

    // Output values for the next cycle: dark during the anti-ghost window,
    // otherwise the current digit, with its segments suppressed while blinking.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        ft_d  = frame_start_s;
        if (blank_s) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end else begin
            an_d = ~(8'd1 << idx_q);
            if (blink_off_s) begin
                seg_d = SEG_OFF;
                dp_d  = 1'b1;
            end else begin
                seg_d = dec_seg_s;
                dp_d  = ~snap_dp_q[idx_q];
            end
        end
    end

    // Scan state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            fcnt_q <= '0;
            bph_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            fcnt_q <= fcnt_d;
            bph_q  <= bph_d;
        end
    end

    // Snapshot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_val_q   <= 32'h0000_0000;
            snap_dp_q    <= 8'h00;
            snap_blink_q <= 8'h00;
        end else begin
            snap_val_q   <= snap_val_d;
            snap_dp_q    <= snap_dp_d;
            snap_blink_q <= snap_blink_d;
        end
    end

    // Output registers; reset forces a dark display.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            ft_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            ft_q  <= ft_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with small parameters. A position-based model derives
// every output from the cycle count since reset release; a compare process
// checks it each cycle, and directed checks pin specific digits and edges.
module tb_seg7_scan;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int BF    = 2;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic [7:0]  blink_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan #(.DIV(DIV), .BLANK_CYC(BLANK), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h3F, 7'h46, 7'h21, 7'h06, 7'h7F};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Model: outputs after the edge that leaves position pp (cycles since release).
    function automatic logic [15:0] model_out(input int pp, input logic [31:0] sv,
                                              input logic [7:0] sd, input logic [7:0] sb);
        int c;
        int slot;
        int frame;
        logic hide;
        logic [3:0] nib;
        logic [7:0] a;
        c     = pp % DIV;
        slot  = (pp / DIV) % 8;
        frame = pp / FRAME;
        if (c < BLANK) return {8'hFF, 7'h7F, 1'b1};
        hide = sb[slot] && (((frame / BF) % 2) == 1);
        nib  = sv[slot*4 +: 4];
        a    = ~(8'd1 << slot);
        if (hide) return {a, 7'h7F, 1'b1};
        return {a, tab[nib], ~sd[slot]};
    endfunction

    int          p     = 0;
    int          edges = 0;
    logic        valid = 1'b0;
    logic [31:0] m_val;
    logic [7:0]  m_dp;
    logic [7:0]  m_blink;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_ft;

    // Model update on each active edge.
    always @(posedge clk) begin
        valid <= 1'b1;
        if (reset) begin
            p       <= 0;
            edges   <= 0;
            m_val   <= 32'h0;
            m_dp    <= 8'h0;
            m_blink <= 8'h0;
            {e_an, e_seg, e_dp} <= {8'hFF, 7'h7F, 1'b1};
            e_ft    <= 1'b0;
        end else begin
            {e_an, e_seg, e_dp} <= model_out(p, m_val, m_dp, m_blink);
            e_ft  <= ((p % FRAME) == 0);
            if ((p % FRAME) == 0) begin
                m_val   <= value;
                m_dp    <= dp_mask;
                m_blink <= blink_mask;
            end
            p     <= p + 1;
            edges <= edges + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            chk("model_an", {24'h0, an}, {24'h0, e_an});
            chk("model_seg", {25'h0, seg}, {25'h0, e_seg});
            chk("model_dp", {31'h0, dp}, {31'h0, e_dp});
            chk("model_ft", {31'h0, frame_tick}, {31'h0, e_ft});
        end
    end

    task automatic goto_edge(input int target);
        int guard;
        guard = 0;
        while (edges < target && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        chk("goto_edge", edges, target);
    endtask

    task automatic lit(input string nm, input logic [7:0] ea, input logic [6:0] es, input logic ed);
        chk({nm, "_an"}, {24'h0, an}, {24'h0, ea});
        chk({nm, "_seg"}, {25'h0, seg}, {25'h0, es});
        chk({nm, "_dp"}, {31'h0, dp}, {31'h0, ed});
    endtask

    initial begin
        reset      = 1'b1;
        value      = 32'h19B49B54;
        dp_mask    = 8'h00;
        blink_mask = 8'h00;
        repeat (3) @(negedge clk);
        lit("rst", 8'hFF, 7'h7F, 1'b1);
        chk("rst_ft", {31'h0, frame_tick}, 32'h0);
        reset = 1'b0;

        // Reset release timing and first frame digits
        goto_edge(1);  chk("t1_ft_e1", {31'h0, frame_tick}, 32'h1); lit("t1_e1", 8'hFF, 7'h7F, 1'b1);
        goto_edge(2);  chk("t1_ft_e2", {31'h0, frame_tick}, 32'h0); lit("t1_e2", 8'hFF, 7'h7F, 1'b1);
        goto_edge(3);  lit("t1_e3", 8'hFE, 7'h19, 1'b1);
        goto_edge(8);  lit("t2_e8", 8'hFE, 7'h19, 1'b1);
        goto_edge(9);  lit("t2_e9", 8'hFF, 7'h7F, 1'b1);
        goto_edge(11); lit("t1_slot1", 8'hFD, 7'h12, 1'b1);
        goto_edge(19); lit("t1_slot2", 8'hFB, 7'h3F, 1'b1);
        goto_edge(59); lit("t1_slot7", 8'h7F, 7'h79, 1'b1);
        goto_edge(65); chk("t2_ft_e65", {31'h0, frame_tick}, 32'h1);
        goto_edge(66); chk("t2_ft_e66", {31'h0, frame_tick}, 32'h0);
        goto_edge(129); chk("t2_ft_e129", {31'h0, frame_tick}, 32'h1);

        // Input change mid-frame stays hidden until the next frame
        goto_edge(156); value = 32'h00000000;
        goto_edge(163); lit("t3_d4_old", 8'hEF, 7'h19, 1'b1);
        goto_edge(171); lit("t3_d5_old", 8'hDF, 7'h3F, 1'b1);
        goto_edge(195); lit("t3_d0_new", 8'hFE, 7'h40, 1'b1);
        goto_edge(219); lit("t3_d3_new", 8'hF7, 7'h40, 1'b1);

        // Sweep all 16 codes on digit 0 with its decimal point lit
        for (int n = 0; n < 16; n++) begin
            goto_edge(FRAME * (4 + n) - 30);
            value   = 32'(n);
            dp_mask = 8'h01;
            goto_edge(FRAME * (4 + n) + 3);
            lit($sformatf("t4_code%0d", n), 8'hFE, tab[n], 1'b0);
            goto_edge(FRAME * (4 + n) + 11);
            lit($sformatf("t4_d1_%0d", n), 8'hFD, 7'h40, 1'b1);
        end

        // Blink on digits 0 and 1, aligned by a fresh reset
        goto_edge(1230);
        reset      = 1'b1;
        value      = 32'h12345678;
        dp_mask    = 8'h03;
        blink_mask = 8'h03;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        goto_edge(3);   lit("t5_f0_d0", 8'hFE, 7'h00, 1'b0);
        goto_edge(11);  lit("t5_f0_d1", 8'hFD, 7'h78, 1'b0);
        goto_edge(131); lit("t5_f2_d0", 8'hFE, 7'h7F, 1'b1);
        goto_edge(139); lit("t5_f2_d1", 8'hFD, 7'h7F, 1'b1);
        goto_edge(147); lit("t5_f2_d2", 8'hFB, 7'h02, 1'b1);
        goto_edge(195); lit("t5_f3_d0", 8'hFE, 7'h7F, 1'b1);
        goto_edge(259); lit("t5_f4_d0", 8'hFE, 7'h00, 1'b0);
        goto_edge(331); lit("t5_f5_d1", 8'hFD, 7'h78, 1'b0);

        // Reset in the middle of digit 5
        goto_edge(364); lit("t6_pre", 8'hDF, 7'h30, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        lit("t6_rst", 8'hFF, 7'h7F, 1'b1);
        chk("t6_rst_ft", {31'h0, frame_tick}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        goto_edge(1); chk("t6_ft_e1", {31'h0, frame_tick}, 32'h1);
        goto_edge(2); lit("t6_e2", 8'hFF, 7'h7F, 1'b1);
        goto_edge(3); lit("t6_e3", 8'hFE, 7'h00, 1'b0);
        goto_edge(70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
